hc74_seq_ctrl: RTL and testbench
================================

# hc74_seq_ctrl

Command-driven pin sequencer for one dual D flip-flop device of the HC74 type. It accepts simple commands over a valid/ready handshake: load, 2-stage shift, preset, clear and read-back. For each command it generates the device's S/R/Clk/D pin waveforms with programmable setup, pulse and hold widths, then samples Q1/Q2. It sits between a host-side command source and the flip-flop model or board pins.

## Interface
Parameters:
- SETUP_CYC, default 2: cycles D is held stable before a Clk rising edge; legal range 1..255.
- PULSE_CYC, default 2: Clk-high width, and also the S/R assertion width; legal range 1..255.
- HOLD_CYC, default 2: cycles after Clk falls, or after S/R release, before sampling; legal range 1..255.

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  reset, synchronous, active-high.
- CmdValid  in  1  command present.
- CmdReady  out  1  controller idle and able to accept a command.
- Cmd  in  3  command code: 000 NOP/read, 001 LOAD, 010 SHIFT, 011 SET, 100 CLEAR; 101..111 are illegal.
- Sel  in  2  flop select for LOAD/SET/CLEAR; bit0 selects flop 1, bit1 selects flop 2.
- Data  in  2  LOAD data; bit0 goes to D1, bit1 goes to D2.
- SerIn  in  1  SHIFT serial input to D1.
- Q1, Q2  in  1 each  device outputs.
- S1, R1, Clk1, D1, S2, R2, Clk2, D2  out  1 each  device pins; S and R are active-low.
- QOut  out  2  sampled value {Q2,Q1}.
- Done  out  1  one-cycle pulse when a command completes.
- Err  out  1  one-cycle pulse when a command is rejected.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, ASSERT, DONE, ERR. A single down-counter times the states.
- CmdReady = (state == IDLE), decoded from the state register. No command is accepted outside IDLE.
- Accept occurs on the edge where CmdValid && CmdReady. Cmd, Sel, Data and SerIn are registered at accept; later input changes are ignored.
- NOP: IDLE → DONE.
- LOAD with Sel != 0:
  - IDLE → SETUP: drive D1 = Data[0] and D2 = Data[1] for the selected flops; unselected D pins are unchanged.
  - → PULSE: Clk of each selected flop is high.
  - → HOLD: all Clk pins low, D pins held.
  - → DONE.
- SHIFT: at accept, D1 = SerIn and D2 = the Q1 input value sampled on the accept edge. Then the same SETUP/PULSE/HOLD/DONE sequence as LOAD, with both Clk pins pulsed simultaneously.
- SET / CLEAR with Sel != 0:
  - IDLE → ASSERT: S (SET) or R (CLEAR) of each selected flop is driven low.
  - → HOLD: all S/R pins back high.
  - → DONE.
- Illegal Cmd, or LOAD/SET/CLEAR with Sel == 0: IDLE → ERR. No pin changes. ERR lasts 1 cycle, then IDLE.
- DONE: on entry, QOut <= {Q2,Q1} and Done = 1 for exactly one cycle, then IDLE.
- S and R are never driven low simultaneously on the same flop. A Clk pulse and S/R assertion never overlap.

## Timing
- All outputs are registered, except CmdReady.
- Reset values:
  - S1 = R1 = S2 = R2 = 1.
  - Clk1 = Clk2 = 0, D1 = D2 = 0.
  - QOut = 00, Done = 0, Err = 0.
  - state IDLE, so CmdReady = 1.
- Rst asserted mid-command: on the next edge all pins return to reset values. Any Clk or S/R pulse is truncated, and no Done or Err is issued.
- Edge numbering: accept edge = edge 0.
  - LOAD/SHIFT: D valid from edge 0; Clk high from edge SETUP_CYC to edge SETUP_CYC+PULSE_CYC; Done high at edge SETUP_CYC+PULSE_CYC+HOLD_CYC+1. With defaults: Clk high at edges 2..4, Done at edge 7.
  - SET/CLEAR: S/R low from edge 0 to edge PULSE_CYC; Done at edge PULSE_CYC+HOLD_CYC+1. With defaults: Done at edge 5.
  - NOP: Done at edge 1. Rejected command: Err at edge 1.
- CmdReady returns high the cycle after Done or Err. Back-to-back commands therefore have one idle cycle of turnaround.
- A CmdValid held high while CmdReady is low is not dropped. It is accepted on the first edge back in IDLE.

## Test plan
- Reset: hold Rst for 2 cycles → every pin at its reset value, CmdReady = 1, QOut = 00, no Done.
- LOAD with Sel = 11, Data = 10 (defaults) → D1 = 0 and D2 = 1 from edge 0, both Clk high during edges 2..4, Done at edge 7 with QOut = 10.
- SHIFT ×2 with SerIn = 1 then 0, starting from QOut = 00 → after the first command QOut = 01; after the second QOut = 10. D2 for the second SHIFT equals Q1 = 1 sampled at accept.
- SET with Sel = 01, then CLEAR with Sel = 11 → S1 low for 2 cycles only, Done at edge 5 with QOut = x1; then R1 and R2 low together, QOut = 00. S and R never both low.
- Illegal Cmd = 110, and LOAD with Sel = 00 → Err pulse at edge 1, no pin toggles, CmdReady high at edge 2.
- Rst asserted at edge 3 of a LOAD → Clk pins 0 at the next edge, no Done, CmdReady = 1. A new NOP afterwards completes with Done at edge 1.

Source files
------------

// File: rtl/hc74_seq_ctrl.sv
// rtl/hc74_seq_ctrl.sv - command-driven S/R/Clk/D pin sequencer for one dual HC74 flip-flop
module hc74_seq_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [2:0] Cmd,
  input  logic [1:0] Sel,
  input  logic [1:0] Data,
  input  logic       SerIn,
  input  logic       Q1,
  input  logic       Q2,
  output logic       S1,
  output logic       R1,
  output logic       Clk1,
  output logic       D1,
  output logic       S2,
  output logic       R2,
  output logic       Clk2,
  output logic       D2,
  output logic [1:0] QOut,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ASSERT, DONE, ERR} state_t;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_SHIFT = 3'b010;
  localparam logic [2:0] CMD_SET   = 3'b011;
  localparam logic [2:0] CMD_CLEAR = 3'b100;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [1:0] d_q, d_nxt;
  logic [1:0] clk_q, clk_nxt;
  logic [1:0] s_q, s_nxt;
  logic [1:0] r_q, r_nxt;
  logic [1:0] qout_q, qout_nxt;
  logic       done_q, done_nxt;
  logic       err_q, err_nxt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      sel_q  <= 2'b00;
      d_q    <= 2'b00;
      clk_q  <= 2'b00;
      s_q    <= 2'b11;
      r_q    <= 2'b11;
      qout_q <= 2'b00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sel_q  <= sel_nxt;
      d_q    <= d_nxt;
      clk_q  <= clk_nxt;
      s_q    <= s_nxt;
      r_q    <= r_nxt;
      qout_q <= qout_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  // DONE and ERR each hold two cycles: pulse in the second, so CmdReady rises after it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    d_nxt     = d_q;
    clk_nxt   = clk_q;
    s_nxt     = s_q;
    r_nxt     = r_q;
    qout_nxt  = qout_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (CmdValid) begin
          sel_nxt   = Sel;
          cnt_nxt   = 8'd1;
          state_nxt = ERR;
          case (Cmd)
            CMD_NOP: state_nxt = DONE;
            CMD_LOAD: begin
              if (Sel != 2'b00) begin
                state_nxt = SETUP;
                cnt_nxt   = SETUP_LD;
                d_nxt[0]  = Sel[0] ? Data[0] : d_q[0];
                d_nxt[1]  = Sel[1] ? Data[1] : d_q[1];
              end
            end
            CMD_SHIFT: begin
              sel_nxt   = 2'b11;
              state_nxt = SETUP;
              cnt_nxt   = SETUP_LD;
              d_nxt     = {Q1, SerIn};
            end
            CMD_SET: begin
              if (Sel != 2'b00) begin
                state_nxt = ASSERT;
                cnt_nxt   = PULSE_LD;
                s_nxt     = ~Sel;
              end
            end
            CMD_CLEAR: begin
              if (Sel != 2'b00) begin
                state_nxt = ASSERT;
                cnt_nxt   = PULSE_LD;
                r_nxt     = ~Sel;
              end
            end
            default: ;
          endcase
        end
      end
      SETUP: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
          clk_nxt   = sel_q;
        end
      end
      PULSE: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
          clk_nxt   = 2'b00;
        end
      end
      ASSERT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
          s_nxt     = 2'b11;
          r_nxt     = 2'b11;
        end
      end
      HOLD: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_nxt = DONE;
          cnt_nxt   = 8'd1;
        end
      end
      DONE: begin
        if (cnt != 8'd0) begin
          done_nxt = 1'b1;
          qout_nxt = {Q2, Q1};
          cnt_nxt  = 8'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        if (cnt != 8'd0) begin
          err_nxt = 1'b1;
          cnt_nxt = 8'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign CmdReady     = (state == IDLE);
  assign {S2, S1}     = s_q;
  assign {R2, R1}     = r_q;
  assign {Clk2, Clk1} = clk_q;
  assign {D2, D1}     = d_q;
  assign QOut         = qout_q;
  assign Done         = done_q;
  assign Err          = err_q;

endmodule

// File: tb/tb_hc74_seq_ctrl.sv
// tb/tb_hc74_seq_ctrl.sv - table-driven bench for hc74_seq_ctrl with a behavioural HC74 model
module tb_hc74_seq_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic [2:0] Cmd = 3'b000;
  logic [1:0] Sel = 2'b00;
  logic [1:0] Data = 2'b00;
  logic       SerIn = 1'b0;
  logic       Q1 = 1'b0;
  logic       Q2 = 1'b0;
  logic       S1, R1, Clk1, D1, S2, R2, Clk2, D2;
  logic [1:0] QOut;
  logic       Done, Err;

  hc74_seq_ctrl #(.SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(2)) dut (
    .Clk(Clk), .Rst(Rst), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .Cmd(Cmd), .Sel(Sel), .Data(Data), .SerIn(SerIn), .Q1(Q1), .Q2(Q2),
    .S1(S1), .R1(R1), .Clk1(Clk1), .D1(D1), .S2(S2), .R2(R2), .Clk2(Clk2), .D2(D2),
    .QOut(QOut), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Flip-flop model: asynchronous active-low preset/clear, rising-edge D capture
  always @(posedge Clk1 or negedge S1 or negedge R1)
    if (!S1) Q1 <= 1'b1; else if (!R1) Q1 <= 1'b0; else Q1 <= D1;
  always @(posedge Clk2 or negedge S2 or negedge R2)
    if (!S2) Q2 <= 1'b1; else if (!R2) Q2 <= 1'b0; else Q2 <= D2;

  int checks = 0;
  int failures = 0;
  bit overlap = 1'b0;

  always @(negedge Clk)
    if (!Rst && ((!S1 && !R1) || (!S2 && !R2) || ((Clk1 | Clk2) && (!S1 | !R1 | !S2 | !R2))))
      overlap = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] cmd;
    logic [1:0] sel;
    logic [1:0] data;
    logic       serin;
    bit         err;
    int         lat;
    logic [1:0] q;
  } vec_t;

  vec_t vt[14];

  int r_lat, r_rdy, r_con, r_coff, r_son, r_soff;
  logic r_err;
  logic [1:0] r_q, r_cm, r_sm, r_rm, r_d0;

  task automatic run_cmd(input logic [2:0] c, input logic [1:0] s, input logic [1:0] d, input logic si);
    @(negedge Clk);
    chk("ready_pre", int'(CmdReady), 1);
    CmdValid = 1'b1; Cmd = c; Sel = s; Data = d; SerIn = si;
    @(posedge Clk); #1;
    CmdValid = 1'b0; Cmd = 3'b000; Sel = ~s; Data = ~d; SerIn = ~si;
    r_lat = -1; r_rdy = -1; r_con = -1; r_coff = -1; r_son = -1; r_soff = -1;
    r_err = 1'b0; r_q = 2'b00; r_cm = 2'b00; r_sm = 2'b00; r_rm = 2'b00;
    r_d0 = {D2, D1};
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if ((Done || Err) && r_lat < 0) begin r_lat = k; r_err = Err; r_q = QOut; end
      if ((Clk1 | Clk2) && r_con < 0) r_con = k;
      if (r_con >= 0 && r_coff < 0 && !(Clk1 | Clk2)) r_coff = k;
      if ((!S1 | !R1 | !S2 | !R2) && r_son < 0) r_son = k;
      if (r_son >= 0 && r_soff < 0 && (S1 & R1 & S2 & R2)) r_soff = k;
      r_cm = r_cm | {Clk2, Clk1};
      r_sm = r_sm | {~S2, ~S1};
      r_rm = r_rm | {~R2, ~R1};
      if (k > 0 && CmdReady) begin r_rdy = k; break; end
    end
  endtask

  logic [1:0] d_exp, prev_q;
  bit is_ls, is_sr, done_seen;
  int k;

  initial begin
    //        cmd     sel    data   ser   err lat q
    vt[0]  = '{3'b001, 2'b11, 2'b10, 1'b0, 0, 7, 2'b10};
    vt[1]  = '{3'b100, 2'b11, 2'b00, 1'b0, 0, 5, 2'b00};
    vt[2]  = '{3'b010, 2'b00, 2'b00, 1'b1, 0, 7, 2'b01};
    vt[3]  = '{3'b010, 2'b00, 2'b00, 1'b0, 0, 7, 2'b10};
    vt[4]  = '{3'b011, 2'b01, 2'b00, 1'b0, 0, 5, 2'b11};
    vt[5]  = '{3'b100, 2'b11, 2'b00, 1'b0, 0, 5, 2'b00};
    vt[6]  = '{3'b110, 2'b00, 2'b00, 1'b0, 1, 1, 2'b00};
    vt[7]  = '{3'b001, 2'b00, 2'b11, 1'b0, 1, 1, 2'b00};
    vt[8]  = '{3'b000, 2'b00, 2'b00, 1'b0, 0, 1, 2'b00};
    vt[9]  = '{3'b001, 2'b01, 2'b11, 1'b0, 0, 7, 2'b01};
    vt[10] = '{3'b011, 2'b10, 2'b00, 1'b0, 0, 5, 2'b11};
    vt[11] = '{3'b111, 2'b11, 2'b11, 1'b1, 1, 1, 2'b11};
    vt[12] = '{3'b001, 2'b10, 2'b00, 1'b0, 0, 7, 2'b01};
    vt[13] = '{3'b100, 2'b00, 2'b00, 1'b0, 1, 1, 2'b01};

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_pins", int'({S1, R1, S2, R2, Clk1, Clk2, D1, D2}), 8'hF0);
    chk("reset_qout", int'(QOut), 0);
    chk("reset_done_err", int'({Done, Err}), 0);
    chk("reset_ready", int'(CmdReady), 1);
    Rst = 1'b0;

    d_exp = 2'b00;
    prev_q = 2'b00;
    for (int i = 0; i < 14; i++) begin
      is_ls = !vt[i].err && (vt[i].cmd == 3'b001 || vt[i].cmd == 3'b010);
      is_sr = !vt[i].err && (vt[i].cmd == 3'b011 || vt[i].cmd == 3'b100);
      if (!vt[i].err && vt[i].cmd == 3'b001) begin
        if (vt[i].sel[0]) d_exp[0] = vt[i].data[0];
        if (vt[i].sel[1]) d_exp[1] = vt[i].data[1];
      end
      if (vt[i].cmd == 3'b010) d_exp = {prev_q[0], vt[i].serin};
      run_cmd(vt[i].cmd, vt[i].sel, vt[i].data, vt[i].serin);
      chk($sformatf("v%0d_lat", i), r_lat, vt[i].lat);
      chk($sformatf("v%0d_err", i), int'(r_err), int'(vt[i].err));
      chk($sformatf("v%0d_qout", i), int'(r_q), int'(vt[i].q));
      chk($sformatf("v%0d_ready", i), r_rdy, vt[i].lat + 1);
      chk($sformatf("v%0d_clk_on", i), r_con, is_ls ? 2 : -1);
      chk($sformatf("v%0d_clk_off", i), r_coff, is_ls ? 4 : -1);
      chk($sformatf("v%0d_sr_on", i), r_son, is_sr ? 0 : -1);
      chk($sformatf("v%0d_sr_off", i), r_soff, is_sr ? 2 : -1);
      chk($sformatf("v%0d_clk_mask", i), int'(r_cm),
          !is_ls ? 0 : (vt[i].cmd == 3'b010 ? 3 : int'(vt[i].sel)));
      chk($sformatf("v%0d_s_mask", i), int'(r_sm), (is_sr && vt[i].cmd == 3'b011) ? int'(vt[i].sel) : 0);
      chk($sformatf("v%0d_r_mask", i), int'(r_rm), (is_sr && vt[i].cmd == 3'b100) ? int'(vt[i].sel) : 0);
      chk($sformatf("v%0d_d_pins", i), int'(r_d0), int'(d_exp));
      prev_q = vt[i].q;
    end

    // CmdValid held through a busy NOP: the SET behind it is taken on the first idle edge
    @(negedge Clk);
    CmdValid = 1'b1; Cmd = 3'b000; Sel = 2'b00;
    @(posedge Clk); #1;
    Cmd = 3'b011; Sel = 2'b01;
    @(posedge Clk); #1;
    chk("held_nop_done", int'(Done), 1);
    @(posedge Clk); #1;
    chk("held_idle_ready", int'(CmdReady), 1);
    chk("held_idle_s1", int'(S1), 1);
    @(posedge Clk); #1;
    chk("held_accept_ready", int'(CmdReady), 0);
    chk("held_accept_s1", int'(S1), 0);
    CmdValid = 1'b0; Cmd = 3'b000; Sel = 2'b00;
    for (k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (Done) break;
    end
    chk("held_set_lat", k, 5);
    chk("held_set_qout", int'(QOut), 1);
    @(posedge Clk); #1;

    // Reset landing on edge 3 of a LOAD truncates the Clk pulse and suppresses Done
    @(negedge Clk);
    CmdValid = 1'b1; Cmd = 3'b001; Sel = 2'b11; Data = 2'b10;
    @(posedge Clk); #1;
    CmdValid = 1'b0; Cmd = 3'b000;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_mid_clk_before", int'({Clk2, Clk1}), 3);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rst_mid_pins", int'({S1, R1, S2, R2, Clk1, Clk2, D1, D2}), 8'hF0);
    chk("rst_mid_ready", int'(CmdReady), 1);
    Rst = 1'b0;
    done_seen = 1'b0;
    repeat (10) begin
      @(posedge Clk); #1;
      done_seen = done_seen | Done | Err;
    end
    chk("rst_mid_no_done", int'(done_seen), 0);
    chk("rst_mid_qout", int'(QOut), 0);
    run_cmd(3'b000, 2'b00, 2'b00, 1'b0);
    chk("post_rst_nop_lat", r_lat, 1);
    chk("post_rst_nop_qout", int'(r_q), 2);

    chk("sr_clk_overlap", int'(overlap), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
